uart_tx_feeder: RTL



---
 rtl/uart_tx_feeder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of uart_top. Releases one byte per
// transmitter frame, pacing on the synchronized uart_done_flag rise.
module uart_tx_feeder #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned START_HOLD = 64,
  parameter int unsigned TIMEOUT    = 1048576
) (
  input  logic          clk_i,
  input  logic          sys_rst_n,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          clr_err_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          busy_o,
  output logic          overflow_o,
  output logic          timeout_o,
  output logic          uartWen,
  output logic [7:0]    uartWData,
  output logic          uart_start,
  input  logic          uart_done_flag
);

  localparam int unsigned CW = 24;
  localparam int unsigned LW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(START_HOLD - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pop_c;
  logic          to_evt_c;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          push_c;
  logic          ovf_evt_c;

  logic          sync1, sync2, sync3;
  logic          done_rise_c;

  // A write is only taken when the FIFO was not full at the edge; a pop the
  // same cycle does not rescue it.
  assign push_c      = wr_en_i & ~full_o;
  assign ovf_evt_c   = wr_en_i & full_o;
  assign done_rise_c = sync2 & ~sync3;
  assign busy_o      = (state != S_IDLE);

  // Two-flop synchronizer plus one edge-detect stage for the baud-domain done.
  always_ff @(posedge clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= uart_done_flag;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // FSM state and shared hold/timeout counter.
  always_ff @(posedge clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: pop in IDLE, hold request in START, await done in WAIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop_c     = 1'b0;
    to_evt_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty_o) begin
          pop_c     = 1'b1;
          cnt_nxt   = HOLD_LOAD;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          cnt_nxt   = '0;
          state_nxt = S_WAIT;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_WAIT: begin
        if (done_rise_c) begin
          state_nxt = S_IDLE;
        end else if (cnt == TO_LAST) begin
          to_evt_c  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next FIFO occupancy from the accepted push and the pop.
  always_comb begin
    level_nxt = level_o;
    if (push_c && !pop_c) begin
      level_nxt = level_o + LW'(1);
    end else if (!push_c && pop_c) begin
      level_nxt = level_o - LW'(1);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_c) begin
      mem[wr_ptr] <= wr_data_i;
    end
  end

  // Pointers, level and registered full/empty flags.
  always_ff @(posedge clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
      full_o  <= 1'b0;
      empty_o <= 1'b1;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level_o <= level_nxt;
      full_o  <= (level_nxt == LVL_FULL);
      empty_o <= (level_nxt == '0);
    end
  end

  // Transmitter request registers; data changes only on a pop.
  always_ff @(posedge clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      uartWData  <= '0;
      uart_start <= 1'b0;
      uartWen    <= 1'b0;
    end else begin
      if (pop_c) begin
        uartWData <= mem[rd_ptr];
      end
      uart_start <= (state == S_START);
      uartWen    <= (state == S_START);
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overflow_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      if (ovf_evt_c) begin
        overflow_o <= 1'b1;
      end else if (clr_err_i) begin
        overflow_o <= 1'b0;
      end
      if (to_evt_c) begin
        timeout_o <= 1'b1;
      end else if (clr_err_i) begin
        timeout_o <= 1'b0;
      end
    end
  end

endmodule
